hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline control producer for the 5-stage core: generates the per-stage active-high hold (`stall*`, wired to the stage flops' `en`) and synchronous clear (`flush*`, wired to `clear`) controls, plus EX-stage operand forwarding selects. It adds three sequential functions to classic hazard detection:

- a data-memory valid/ready wait with a timeout watchdog;
- a debug halt/drain state machine;
- saturating performance counters.

## Interface
- `MEM_TIMEOUT`, default 255: consecutive memory-wait cycles before `mem_err` sets.
- `DRAIN_CYCLES`, default 4: free-flowing bubble cycles needed to empty D/E/M/W.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rsD`, `rtD`, `rsE`, `rtE`  in  5 each  source registers in ID/EX.
- `writeregE`, `writeregM`, `writeregW`  in  5 each  destination registers.
- `regwriteE`, `regwriteM`, `regwriteW`, `memtoregE`  in  1 each  stage control bits.
- `mem_accessM`  in  1  MEM-stage instruction is a load or store.
- `dmem_ready`  in  1  data memory accepts or completes the access this cycle.
- `branch_takenE`  in  1  EX resolved a taken branch or jump; PC mux selects the target.
- `halt_req`  in  1  debug halt request, level.
- `dmem_valid`  out  1  equals `mem_accessM`.
- `stallF`, `stallD`, `stallE`, `stallM`, `stallW`  out  1 each  1 = hold the stage.
- `flushD`, `flushE`, `flushM`, `flushW`  out  1 each  1 = clear the stage (bubble).
- `forwardAE`, `forwardBE`  out  2 each  operand select, `fwd_e`.
- `halted`  out  1  pipeline is empty and frozen.
- `mem_err`  out  1  sticky memory timeout.
- `stall_cnt`, `flush_cnt`  out  32 each  saturating performance counters.

## Operation
**Forwarding** (combinational):
- `forwardAE = FWD_MEM (2'b10)` if `regwriteM && writeregM != 0 && writeregM == rsE`.
- Else `forwardAE = FWD_WB (2'b01)` under the same rule for W.
- Else `forwardAE = FWD_NONE`.
- `forwardBE` follows the same rules on `rtE`.

**Hazard terms:**
- `memstall = mem_accessM && !dmem_ready`.
- `lwstall = memtoregE && regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)`.
- `lwstall` and `branch_takenE` are mutually exclusive, since a load is never a branch.

**Priority**, highest first:
- `memstall`: `stallF/D/E/M = 1`, `flushW = 1`, every other flush 0; a pending `branch_takenE` holds in EX and acts later.
- `lwstall`: `stallF/D = 1`, `flushE = 1`.
- `branch_takenE`: `flushD = flushE = 1`, `stallF = 0` so the PC loads the target.
- Halt state: in DRAIN or HALTED with none of the above, `stallF = 1`, `flushD = 1`.
- Never assert `stallX` and `flushX` on the same stage. `stallW` and `flushM` are always 0.

**Halt FSM** (`halt_state_e`: RUN, DRAIN, HALTED):
- RUN → DRAIN when `halt_req`; `drain_cnt` is cleared.
- DRAIN:
  - `drain_cnt` increments on cycles free of `memstall`, `lwstall` and `branch_takenE`.
  - `lwstall` or `branch_takenE` resets `drain_cnt` to 0.
  - → HALTED when `drain_cnt == DRAIN_CYCLES-1` on a counted cycle.
  - `!halt_req` → RUN.
- HALTED: `halted = 1`; `!halt_req` → RUN.

**Watchdog:**
- `wait_cnt` counts consecutive `memstall` cycles and clears when `memstall` is 0.
- `mem_err` sets when `wait_cnt` reaches `MEM_TIMEOUT`. It clears only on reset. Stalling continues.

**Counters:**
- `stall_cnt` increments on each RUN-state cycle with `stallF = 1`.
- `flush_cnt` increments on each `branch_takenE` cycle that is not masked by `memstall`.
- Both saturate at 32'hFFFF_FFFF.

## Timing
- On reset: state RUN, `drain_cnt`/`wait_cnt`/`stall_cnt`/`flush_cnt` = 0, `mem_err` = 0, `halted` = 0.
- Stall, flush, forward and `dmem_valid` outputs are combinational (zero latency) from inputs and current state. They are therefore 0 at reset when all inputs are 0.
- `halted`, `mem_err` and the counters are registered, and update one cycle after the causing condition.
- `halted` rises exactly `DRAIN_CYCLES` counted cycles after `halt_req` is sampled in RUN. It falls the cycle after `halt_req` drops.
- `mem_err` rises on the cycle after the `MEM_TIMEOUT`-th consecutive `memstall` cycle.
- `rst_n` asserted mid-drain or mid-wait returns everything to reset values immediately.

## Structure
- Shared core package:
  - `fwd_e` (FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10);
  - `halt_state_e`;
  - `DRAIN_CYCLES` default constant.
- One sub-module, `sat_counter` (32-bit, increment enable, saturating, async active-low reset), instantiated twice.
- `wait_cnt` is sized with `$clog2(MEM_TIMEOUT+1)`.

## Test plan
- Forwarding: `writeregM = writeregW = rsE = 5`, `regwriteM = regwriteW = 1` → `forwardAE = 2'b10`. With `regwriteM = 0` → `2'b01`. With register 0 → `2'b00`.
- Load-use: `memtoregE = regwriteE = 1`, `writeregE = rtD = 7` → `stallF = stallD = 1`, `flushE = 1`, `stall_cnt` +1.
- Memory wait: `mem_accessM = 1`, `dmem_ready` low for 3 cycles, with `branch_takenE = 1` throughout → `stallF/D/E/M = 1` and `flushW = 1` for 3 cycles, no `flushD`. When ready rises: `flushD = flushE = 1`, and `flush_cnt` = 1.
- Timeout: `MEM_TIMEOUT = 4`, `dmem_ready = 0` for 6 cycles → `mem_err` rises after the 4th cycle and stays high after ready returns, until `rst_n` goes low.
- Halt: `halt_req` rises in RUN with a quiet pipe → `stallF = flushD = 1` from the next cycle, `halted = 1` 4 cycles later. Dropping `halt_req` → `halted = 0` the next cycle.
- Drain interrupted: `branch_takenE` in the 2nd drain cycle → `stallF = 0`, `flushD = flushE = 1`, and `halted` delayed to 4 counted cycles after the branch.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_pkg
// Description : Shared types and defaults for the pipeline hazard unit:
//               forwarding select encoding, debug halt states, and the
//               default drain length.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

  // EX-stage operand source select
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

  // Debug halt state machine
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } halt_state_e;

  // Bubble cycles needed to empty D/E/M/W
  localparam int c_drain_cycles = 4;

  // Operand select for one EX source register; MEM result is younger, so it wins
  function automatic fwd_e fwd_select(
    input logic [4:0] src,
    input logic       regwrite_m,
    input logic [4:0] writereg_m,
    input logic       regwrite_w,
    input logic [4:0] writereg_w
  );
    fwd_e sel;
    sel = FWD_NONE;
    if (regwrite_m && (writereg_m != 5'd0) && (writereg_m == src)) begin
      sel = FWD_MEM;
    end else if (regwrite_w && (writereg_w != 5'd0) && (writereg_w == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with increment enable that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import hazard_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

  // Count enabled cycles, holding once the maximum is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != c_max)) begin
      count <= count + c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline stall/flush/forward control for the 5-stage core,
//               with data-memory wait watchdog, debug halt/drain sequencing
//               and saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = c_drain_cycles
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeregE,
  input  logic [4:0]  writeregM,
  input  logic [4:0]  writeregW,
  input  logic        regwriteE,
  input  logic        regwriteM,
  input  logic        regwriteW,
  input  logic        memtoregE,
  input  logic        mem_accessM,
  input  logic        dmem_ready,
  input  logic        branch_takenE,
  input  logic        halt_req,
  output logic        dmem_valid,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        stallW,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        halted,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [WAIT_W-1:0]  c_wait_max   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]  c_wait_one   = WAIT_W'(1);
  localparam logic [DRAIN_W-1:0] c_drain_last = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] c_drain_one  = DRAIN_W'(1);

  halt_state_e        r_state;
  halt_state_e        w_state_next;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_next;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [WAIT_W-1:0]  w_wait_next;
  logic               r_mem_err;

  logic w_memstall;
  logic w_lwstall;
  logic w_halting;
  logic w_stall_inc;
  logic w_flush_inc;

  // ---------------------------------------------------------------------------
  // Hazard terms
  // ---------------------------------------------------------------------------
  assign w_memstall = mem_accessM && !dmem_ready;
  assign w_lwstall  = memtoregE && regwriteE && (writeregE != 5'd0) &&
                      ((writeregE == rsD) || (writeregE == rtD));
  assign w_halting  = (r_state == DRAIN) || (r_state == HALTED);

  assign dmem_valid = mem_accessM;
  assign forwardAE  = fwd_select(rsE, regwriteM, writeregM, regwriteW, writeregW);
  assign forwardBE  = fwd_select(rtE, regwriteM, writeregM, regwriteW, writeregW);

  // Prioritised stage hold/clear; a memory wait freezes everything up to M,
  // so a taken branch sitting in EX simply waits its turn.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (w_memstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (w_lwstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (branch_takenE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (w_halting) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug halt / drain sequencing
  // ---------------------------------------------------------------------------

  // Halt state register and drain progress counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
    end
  end

  // Next halt state: only bubble cycles that actually advance the pipe count
  // toward an empty pipeline; a new hazard restarts the drain.
  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    case (r_state)
      RUN: begin
        if (halt_req) begin
          w_state_next = DRAIN;
          w_drain_next = '0;
        end
      end
      DRAIN: begin
        if (!halt_req) begin
          w_state_next = RUN;
        end else if (w_lwstall || branch_takenE) begin
          w_drain_next = '0;
        end else if (!w_memstall) begin
          if (r_drain_cnt == c_drain_last) begin
            w_state_next = HALTED;
          end else begin
            w_drain_next = r_drain_cnt + c_drain_one;
          end
        end
      end
      HALTED: begin
        if (!halt_req) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
        w_drain_next = '0;
      end
    endcase
  end

  assign halted = (r_state == HALTED);

  // ---------------------------------------------------------------------------
  // Memory wait watchdog
  // ---------------------------------------------------------------------------

  // Consecutive-wait length, held at the timeout value once reached
  always_comb begin
    w_wait_next = '0;
    if (w_memstall) begin
      w_wait_next = (r_wait_cnt == c_wait_max) ? r_wait_cnt : (r_wait_cnt + c_wait_one);
    end
  end

  // Wait counter and sticky timeout flag; the flag sets on the edge that
  // closes the MEM_TIMEOUT-th consecutive wait cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_next;
      if (w_wait_next == c_wait_max) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign mem_err = r_mem_err;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  assign w_stall_inc = (r_state == RUN) && stallF;
  assign w_flush_inc = branch_takenE && !w_memstall;

  sat_counter #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .WIDTH (32)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_flush_inc),
    .count (flush_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit: directed scenarios with
//               literal expectations plus randomized traffic compared every
//               cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

  localparam int MT = 4;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rsD = '0, rtD = '0, rsE = '0, rtE = '0;
  logic [4:0]  writeregE = '0, writeregM = '0, writeregW = '0;
  logic        regwriteE = 1'b0, regwriteM = 1'b0, regwriteW = 1'b0, memtoregE = 1'b0;
  logic        mem_accessM = 1'b0, dmem_ready = 1'b0, branch_takenE = 1'b0, halt_req = 1'b0;

  logic        dmem_valid;
  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushD, flushE, flushM, flushW;
  logic [1:0]  forwardAE, forwardBE;
  logic        halted, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_unit #(
    .MEM_TIMEOUT  (MT),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rsD           (rsD),
    .rtD           (rtD),
    .rsE           (rsE),
    .rtE           (rtE),
    .writeregE     (writeregE),
    .writeregM     (writeregM),
    .writeregW     (writeregW),
    .regwriteE     (regwriteE),
    .regwriteM     (regwriteM),
    .regwriteW     (regwriteW),
    .memtoregE     (memtoregE),
    .mem_accessM   (mem_accessM),
    .dmem_ready    (dmem_ready),
    .branch_takenE (branch_takenE),
    .halt_req      (halt_req),
    .dmem_valid    (dmem_valid),
    .stallF        (stallF),
    .stallD        (stallD),
    .stallE        (stallE),
    .stallM        (stallM),
    .stallW        (stallW),
    .flushD        (flushD),
    .flushE        (flushE),
    .flushM        (flushM),
    .flushW        (flushW),
    .forwardAE     (forwardAE),
    .forwardBE     (forwardBE),
    .halted        (halted),
    .mem_err       (mem_err),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: mode 0=running, 1=draining, 2=halted
  // ---------------------------------------------------------------------------
  int          m_mode = 0;
  int          m_counted = 0;
  int          m_wait = 0;
  bit          m_err = 1'b0;
  longint      m_stall = 0;
  longint      m_flush = 0;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  function automatic logic [1:0] fwd_model(input logic [4:0] src);
    if (regwriteM && writeregM != 0 && writeregM == src) return 2'd2;
    if (regwriteW && writeregW != 0 && writeregW == src) return 2'd1;
    return 2'd0;
  endfunction

  always @(negedge clk) begin : compare
    bit ms, ls;
    bit eF, eD, eE, eM, fD, fE, fW;
    if (!rst_n) begin
      m_mode = 0; m_counted = 0; m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end
    ms = mem_accessM && !dmem_ready;
    ls = memtoregE && regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
    {eF, eD, eE, eM, fD, fE, fW} = '0;
    if (ms) begin
      eF = 1; eD = 1; eE = 1; eM = 1; fW = 1;
    end else if (ls) begin
      eF = 1; eD = 1; fE = 1;
    end else if (branch_takenE) begin
      fD = 1; fE = 1;
    end else if (m_mode != 0) begin
      eF = 1; fD = 1;
    end
    chk("dmem_valid", dmem_valid, mem_accessM);
    chk("stallF", stallF, eF);
    chk("stallD", stallD, eD);
    chk("stallE", stallE, eE);
    chk("stallM", stallM, eM);
    chk("stallW", stallW, 0);
    chk("flushD", flushD, fD);
    chk("flushE", flushE, fE);
    chk("flushM", flushM, 0);
    chk("flushW", flushW, fW);
    chk("forwardAE", forwardAE, fwd_model(rsE));
    chk("forwardBE", forwardBE, fwd_model(rtE));
    chk("halted", halted, (m_mode == 2));
    chk("mem_err", mem_err, m_err);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    if (rst_n) begin
      if (m_mode == 0 && eF && m_stall < SAT) m_stall++;
      if (branch_takenE && !ms && m_flush < SAT) m_flush++;
      if (ms) m_wait++; else m_wait = 0;
      if (m_wait >= MT) m_err = 1'b1;
      case (m_mode)
        0: if (halt_req) begin m_mode = 1; m_counted = 0; end
        1: begin
          if (!halt_req) m_mode = 0;
          else if (ls || branch_takenE) m_counted = 0;
          else if (!ms) begin
            m_counted++;
            if (m_counted == DC) m_mode = 2;
          end
        end
        default: if (!halt_req) m_mode = 0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic quiet();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0;
    mem_accessM = 0; dmem_ready = 0; branch_takenE = 0;
  endtask

  initial begin
    int burst;
    bit lw;
    quiet();
    repeat (3) step();
    rst_n = 1'b1;
    settle();
    chk("lit_reset_stall_cnt", stall_cnt, 0);
    chk("lit_reset_halted", halted, 0);
    chk("lit_reset_mem_err", mem_err, 0);
    chk("lit_reset_stallF", stallF, 0);

    // Forwarding priority
    step();
    writeregM = 5; writeregW = 5; rsE = 5; regwriteM = 1; regwriteW = 1;
    settle(); chk("lit_fwd_mem", forwardAE, 2'b10);
    step(); regwriteM = 0;
    settle(); chk("lit_fwd_wb", forwardAE, 2'b01);
    step(); regwriteM = 1; writeregM = 0; writeregW = 0; rsE = 0;
    settle(); chk("lit_fwd_r0", forwardAE, 2'b00);

    // Load-use
    step(); quiet(); memtoregE = 1; regwriteE = 1; writeregE = 7; rtD = 7;
    settle();
    chk("lit_lw_stallF", stallF, 1);
    chk("lit_lw_stallD", stallD, 1);
    chk("lit_lw_flushE", flushE, 1);
    step(); quiet();
    settle(); chk("lit_lw_stall_cnt", stall_cnt, 1);

    // Memory wait with a pending branch
    step(); mem_accessM = 1; dmem_ready = 0; branch_takenE = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lit_mw_stallM", stallM, 1);
      chk("lit_mw_flushW", flushW, 1);
      chk("lit_mw_flushD", flushD, 0);
      step();
    end
    dmem_ready = 1;
    settle();
    chk("lit_mw_br_flushD", flushD, 1);
    chk("lit_mw_br_flushE", flushE, 1);
    step(); quiet();
    settle();
    chk("lit_mw_flush_cnt", flush_cnt, 1);
    chk("lit_mw_stall_cnt", stall_cnt, 4);

    // Watchdog timeout
    step(); mem_accessM = 1; dmem_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      settle();
      chk("lit_to_mem_err", mem_err, (k >= 5));
      step();
    end
    dmem_ready = 1;
    settle(); chk("lit_to_sticky", mem_err, 1);
    step(); quiet();
    settle(); chk("lit_to_sticky2", mem_err, 1);
    step(); rst_n = 1'b0; #1;
    chk("lit_to_reset", mem_err, 0);
    chk("lit_to_reset_cnt", stall_cnt, 0);
    settle();
    step(); rst_n = 1'b1;

    // Halt on a quiet pipe
    step(); halt_req = 1;
    settle(); chk("lit_h_run_stallF", stallF, 0);
    step();
    settle();
    chk("lit_h_stallF", stallF, 1);
    chk("lit_h_flushD", flushD, 1);
    for (int d = 0; d < 3; d++) begin
      step(); settle(); chk("lit_h_not_yet", halted, 0);
    end
    step(); settle(); chk("lit_h_halted", halted, 1);
    step(); halt_req = 0;
    settle(); chk("lit_h_still", halted, 1);
    step(); settle(); chk("lit_h_release", halted, 0);

    // Drain interrupted by a branch in its 2nd cycle
    step(); halt_req = 1;
    step();
    step(); branch_takenE = 1;
    settle();
    chk("lit_di_stallF", stallF, 0);
    chk("lit_di_flushD", flushD, 1);
    chk("lit_di_flushE", flushE, 1);
    step(); branch_takenE = 0;
    for (int d = 0; d < 4; d++) begin
      settle(); chk("lit_di_not_yet", halted, 0); step();
    end
    settle(); chk("lit_di_halted", halted, 1);
    step(); halt_req = 0;
    step();

    // Randomized traffic, alternating busy and calm phases
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      bit calm;
      step();
      calm = ((i / 200) % 2) == 1;
      rst_n = ($urandom_range(0, 499) != 0);
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      memtoregE = calm ? 1'b0 : ($urandom_range(0, 3) == 0);
      mem_accessM = calm ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      dmem_ready = ($urandom_range(0, 3) != 0);
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = 7;
      if (burst > 0) begin
        mem_accessM = 1; dmem_ready = 0; burst--;
      end
      branch_takenE = calm ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 5) == 0);
      lw = memtoregE && regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
      if (lw) branch_takenE = 0;
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
    end
    step(); rst_n = 1'b1; quiet(); halt_req = 0;
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
